// File: rtl/maze_cell_ctrl.sv
// Cell-level read-modify-write controller in front of the 64-row maze memory.
// Define MAZE_BORDER_EN to make the reset-time sweep write a walled border instead of all zeros.
module maze_cell_ctrl #(
    parameter int ROW_BITS = 64,
    parameter int COL_W    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [5:0]          req_row,
    input  logic [COL_W-1:0]    req_col,
    output logic                rsp_valid,
    output logic                rsp_bit,
    output logic                init_done,
    output logic [5:0]          mem_addr,
    output logic                mem_cmd,
    inout  wire  [ROW_BITS-1:0] mem_data
);

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4
    } state_t;

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_SET    = 2'd1;
    localparam logic [1:0] OP_CLEAR  = 2'd2;
    localparam logic [1:0] OP_TOGGLE = 2'd3;

    state_t              state_r, state_s;
    logic [5:0]          init_cnt_r, init_cnt_s;
    logic [1:0]          op_r, op_s;
    logic [COL_W-1:0]    col_r, col_s;
    logic [ROW_BITS-1:0] row_q_r, row_q_s;
    logic [ROW_BITS-1:0] drv_data_r, drv_data_s;
    logic [5:0]          mem_addr_r, mem_addr_s;
    logic                mem_cmd_r, mem_cmd_s;
    logic                req_ready_r, req_ready_s;
    logic                rsp_valid_r, rsp_valid_s;
    logic                rsp_bit_r, rsp_bit_s;
    logic                init_done_r, init_done_s;

    function automatic logic [ROW_BITS-1:0] init_pattern(input logic [5:0] row);
        logic [ROW_BITS-1:0] pat;
`ifdef MAZE_BORDER_EN
        if ((row == 6'd0) || (row == 6'd63)) begin
            pat = '1;
        end else begin
            pat = '0;
            pat[0] = 1'b1;
            pat[ROW_BITS-1] = 1'b1;
        end
`else
        pat = '0;
        if (row == 6'd0) begin
            pat = '0;
        end else begin
            pat = '0;
        end
`endif
        return pat;
    endfunction

    function automatic logic [ROW_BITS-1:0] modify_row(input logic [ROW_BITS-1:0] row,
                                                       input logic [COL_W-1:0]    col,
                                                       input logic [1:0]          op);
        logic [ROW_BITS-1:0] res;
        res = row;
        case (op)
            OP_SET:    res[col] = 1'b1;
            OP_CLEAR:  res[col] = 1'b0;
            OP_TOGGLE: res[col] = ~row[col];
            default:   res = row;
        endcase
        return res;
    endfunction

    // The DUT owns the bus only during write cycles; the memory drives it otherwise.
    assign mem_data  = mem_cmd_r ? {ROW_BITS{1'bz}} : drv_data_r;
    assign mem_addr  = mem_addr_r;
    assign mem_cmd   = mem_cmd_r;
    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_bit   = rsp_bit_r;
    assign init_done = init_done_r;

    // Next-state and next-output decode; every output is registered from these values.
    always_comb begin
        state_s     = state_r;
        init_cnt_s  = init_cnt_r;
        op_s        = op_r;
        col_s       = col_r;
        row_q_s     = row_q_r;
        drv_data_s  = drv_data_r;
        mem_addr_s  = mem_addr_r;
        mem_cmd_s   = 1'b1;
        req_ready_s = req_ready_r;
        rsp_valid_s = 1'b0;
        rsp_bit_s   = rsp_bit_r;
        init_done_s = init_done_r;
        case (state_r)
            ST_INIT: begin
                // The edge that sees row 63 on the bus is the one that writes it.
                if (!mem_cmd_r && (mem_addr_r == 6'd63)) begin
                    state_s     = ST_IDLE;
                    init_done_s = 1'b1;
                    req_ready_s = 1'b1;
                end else begin
                    mem_cmd_s  = 1'b0;
                    mem_addr_s = init_cnt_r;
                    drv_data_s = init_pattern(init_cnt_r);
                    init_cnt_s = init_cnt_r + 6'd1;
                end
            end
            ST_IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid && req_ready_r) begin
                    op_s        = req_op;
                    col_s       = req_col;
                    mem_addr_s  = req_row;
                    req_ready_s = 1'b0;
                    state_s     = ST_RD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                row_q_s = mem_data;
                if (op_r == OP_READ) begin
                    state_s     = ST_RSP;
                    rsp_valid_s = 1'b1;
                    rsp_bit_s   = mem_data[col_r];
                end else begin
                    state_s    = ST_WR;
                    mem_cmd_s  = 1'b0;
                    drv_data_s = modify_row(mem_data, col_r, op_r);
                end
            end
            ST_WR: begin
                state_s     = ST_RSP;
                rsp_valid_s = 1'b1;
                rsp_bit_s   = row_q_r[col_r];
            end
            ST_RSP: begin
                state_s     = ST_IDLE;
                req_ready_s = 1'b1;
            end
            default: begin
                state_s     = ST_INIT;
                init_cnt_s  = 6'd0;
                mem_addr_s  = 6'd0;
                req_ready_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces the bus released immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            init_cnt_r  <= 6'd0;
            op_r        <= 2'd0;
            col_r       <= '0;
            row_q_r     <= '0;
            drv_data_r  <= '0;
            mem_addr_r  <= 6'd0;
            mem_cmd_r   <= 1'b1;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_bit_r   <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            init_cnt_r  <= init_cnt_s;
            op_r        <= op_s;
            col_r       <= col_s;
            row_q_r     <= row_q_s;
            drv_data_r  <= drv_data_s;
            mem_addr_r  <= mem_addr_s;
            mem_cmd_r   <= mem_cmd_s;
            req_ready_r <= req_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_bit_r   <= rsp_bit_s;
            init_done_r <= init_done_s;
        end
    end

endmodule

// File: tb/tb_maze_cell_ctrl.sv
// Bench for maze_cell_ctrl: bus-level memory model, vector table, random requests and corner sequences.
module tb_maze_cell_ctrl;

    localparam int ROW_BITS = 64;
    localparam int COL_W    = 6;
`ifdef MAZE_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [1:0]         req_op;
    logic [5:0]         req_row;
    logic [COL_W-1:0]   req_col;
    logic               rsp_valid;
    logic               rsp_bit;
    logic               init_done;
    logic [5:0]         mem_addr;
    logic               mem_cmd;
    wire  [ROW_BITS-1:0] mem_data;

    logic [63:0] mem   [64];
    logic [63:0] model [64];
    bit          scramble;
    int          total;
    int          passed;

    always #10 clk = ~clk;

    maze_cell_ctrl #(.ROW_BITS(ROW_BITS), .COL_W(COL_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_row(req_row), .req_col(req_col), .rsp_valid(rsp_valid),
        .rsp_bit(rsp_bit), .init_done(init_done), .mem_addr(mem_addr), .mem_cmd(mem_cmd),
        .mem_data(mem_data)
    );

    // Row memory: combinational read while mem_cmd=1, write on every edge with mem_cmd=0.
    assign mem_data = mem_cmd ? mem[mem_addr] : {ROW_BITS{1'bz}};
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 64; i++) mem[i] <= {$urandom, $urandom};
        end else if (!mem_cmd) begin
            mem[mem_addr] <= mem_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 1 ms");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    function automatic logic [63:0] pattern(input int r);
        logic [63:0] p;
        p = 64'd0;
        if (BORDER) begin
            if (r == 0 || r == 63) p = {64{1'b1}};
            else p = 64'h8000_0000_0000_0001;
        end
        return p;
    endfunction

    // Reference: a cell operation returns the old bit and updates the model row.
    function automatic logic apply_model(input logic [1:0] op, input int r, input int c);
        logic prior;
        prior = model[r][c];
        case (op)
            2'd1:    model[r][c] = 1'b1;
            2'd2:    model[r][c] = 1'b0;
            2'd3:    model[r][c] = ~prior;
            default: ;
        endcase
        return prior;
    endfunction

    task automatic chk_reset_values();
        chk("rst_mem_cmd", 64'(mem_cmd), 64'd1);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_bit", 64'(rsp_bit), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
    endtask

    // Watch the sweep from reset release until init_done, then check memory contents.
    task automatic run_init_check();
        int n_wr, cyc, last, bad_addr, bad_ready, bad_rsp, bad_rows;
        n_wr = 0; cyc = 0; last = -1; bad_addr = 0; bad_ready = 0; bad_rsp = 0; bad_rows = 0;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (init_done === 1'b1) break;
            if (mem_cmd === 1'b0) begin
                if (32'(mem_addr) != n_wr) bad_addr++;
                n_wr++;
                last = cyc;
            end
            if (req_ready !== 1'b0) bad_ready++;
            if (rsp_valid !== 1'b0) bad_rsp++;
        end
        chk("init_done_set", 64'(init_done), 64'd1);
        chk("init_write_cycles", 64'(n_wr), 64'd64);
        chk("init_done_timing", 64'(cyc), 64'(last + 1));
        chk("init_addr_seq_errs", 64'(bad_addr), 64'd0);
        chk("init_ready_low_errs", 64'(bad_ready), 64'd0);
        chk("init_rsp_spurious", 64'(bad_rsp), 64'd0);
        for (int r = 0; r < 64; r++) begin
            model[r] = pattern(r);
            if (mem[r] !== model[r]) bad_rows++;
        end
        chk("init_rows_bad", 64'(bad_rows), 64'd0);
    endtask

    task automatic do_req(input logic [1:0] op, input logic [5:0] row, input logic [5:0] col,
                          output logic bitv, output int lat, output int nwr);
        int guard;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_op = op; req_row = row; req_col = col;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op = 2'($urandom); req_row = 6'($urandom); req_col = 6'($urandom);
        lat = 1; nwr = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            if (mem_cmd === 1'b0) nwr++;
            @(negedge clk);
            lat++;
        end
        if (rsp_valid !== 1'b1) lat = -1;
        if (mem_cmd === 1'b0) nwr++;
        bitv = rsp_bit;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [5:0] row;
        logic [5:0] col;
        logic       exp_bit;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic       got, expb;
        int         lat, nwr, bad_rows;
        logic [1:0] op;
        logic [5:0] row, col;
        logic       exp_q [$];
        int         acc_cyc [$];
        int         n_acc, n_rsp, k, gap_bad;
        bit         pending;

        vecs[0] = '{2'd1, 6'd5,  6'd10, 1'b0};
        vecs[1] = '{2'd0, 6'd5,  6'd10, 1'b1};
        vecs[2] = '{2'd3, 6'd63, 6'd63, BORDER};
        vecs[3] = '{2'd3, 6'd63, 6'd63, ~BORDER};
        vecs[4] = '{2'd0, 6'd7,  6'd0,  BORDER};
        vecs[5] = '{2'd0, 6'd7,  6'd10, 1'b0};
        vecs[6] = '{2'd2, 6'd5,  6'd10, 1'b1};
        vecs[7] = '{2'd0, 6'd5,  6'd10, 1'b0};
        vecs[8] = '{2'd1, 6'd5,  6'd11, 1'b0};
        vecs[9] = '{2'd2, 6'd1,  6'd63, BORDER};

        total = 0; passed = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_row = 6'd0; req_col = 6'd0;
        scramble = 1'b1;
        @(negedge clk);
        scramble = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_values();
        rst_n = 1'b1;
        run_init_check();

        // Directed vector table.
        for (int i = 0; i < 10; i++) begin
            expb = apply_model(vecs[i].op, int'(vecs[i].row), int'(vecs[i].col));
            do_req(vecs[i].op, vecs[i].row, vecs[i].col, got, lat, nwr);
            chk($sformatf("vec%0d_rsp_bit", i), 64'(got), 64'(vecs[i].exp_bit));
            chk($sformatf("vec%0d_latency", i), 64'(lat), (vecs[i].op == 2'd0) ? 64'd2 : 64'd3);
            chk($sformatf("vec%0d_write_cycles", i), 64'(nwr), (vecs[i].op == 2'd0) ? 64'd0 : 64'd1);
            if (i == 1) chk("row5_after_set", mem[5], 64'h400 | pattern(5));
            @(negedge clk);
            chk($sformatf("vec%0d_rsp_pulse_end", i), 64'(rsp_valid), 64'd0);
            if (expb !== vecs[i].exp_bit) $display("note: table entry %0d disagrees with model", i);
        end
        chk("row5_final", mem[5], 64'h800 | pattern(5));
        chk("row63_final", mem[63], BORDER ? {64{1'b1}} : 64'd0);
        chk("row7_unchanged", mem[7], pattern(7));
        chk("row1_col63_cleared", mem[1], pattern(1) & 64'h7FFF_FFFF_FFFF_FFFF);

        // Random requests against the reference model.
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            row = 6'($urandom);
            col = 6'($urandom);
            expb = apply_model(op, int'(row), int'(col));
            do_req(op, row, col, got, lat, nwr);
            chk($sformatf("rand%0d_rsp_bit", i), 64'(got), 64'(expb));
            chk($sformatf("rand%0d_latency", i), 64'(lat), (op == 2'd0) ? 64'd2 : 64'd3);
        end
        bad_rows = 0;
        for (int r = 0; r < 64; r++) if (mem[r] !== model[r]) bad_rows++;
        chk("rand_rows_bad", 64'(bad_rows), 64'd0);

        // req_valid held high with alternating set/clear on row 0 col 3.
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd1; req_row = 6'd0; req_col = 6'd3;
        n_acc = 0; n_rsp = 0; k = 0; pending = 1'b0; gap_bad = 0;
        while (k < 60 && n_rsp < 6) begin
            if (pending) begin
                req_op = (req_op == 2'd1) ? 2'd2 : 2'd1;
                if (n_acc == 6) req_valid = 1'b0;
                pending = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                n_rsp++;
                if (exp_q.size() > 0) chk($sformatf("hold_rsp%0d_bit", n_rsp), 64'(rsp_bit), 64'(exp_q.pop_front()));
                else chk("hold_rsp_unexpected", 64'd1, 64'd0);
            end
            if (req_valid && req_ready === 1'b1) begin
                pending = 1'b1;
                n_acc++;
                exp_q.push_back(apply_model(req_op, 0, 3));
                if (acc_cyc.size() > 0 && (k - acc_cyc[acc_cyc.size()-1]) != 4) gap_bad++;
                acc_cyc.push_back(k);
            end
            @(negedge clk);
            k++;
        end
        req_valid = 1'b0;
        repeat (4) begin
            if (rsp_valid === 1'b1) n_rsp++;
            @(negedge clk);
        end
        chk("hold_accepts", 64'(n_acc), 64'd6);
        chk("hold_rsps", 64'(n_rsp), 64'd6);
        chk("hold_accept_spacing_errs", 64'(gap_bad), 64'd0);
        chk("hold_row0", mem[0], model[0]);

        // Reset asserted in the middle of a WR cycle.
        while (req_ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        req_valid = 1'b1; req_op = 2'd1; req_row = 6'd9; req_col = 6'd2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_in_wr_cycle", 64'(mem_cmd), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_cmd_async", 64'(mem_cmd), 64'd1);
        chk("abort_ready_async", 64'(req_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        chk_reset_values();
        rst_n = 1'b1;
        run_init_check();

        op = 2'd0;
        do_req(op, 6'd9, 6'd2, got, lat, nwr);
        chk("post_abort_row9_bit", 64'(got), 64'(pattern(9) >> 2) & 64'd1);
        chk("post_abort_latency", 64'(lat), 64'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/maze_cell_ctrl.md
Name: maze_cell_ctrl

Overview:
- Cell-level access controller directly upstream of the maze row memory (64 rows × ROW_BITS, 6-bit address, command 1=read / 0=write, shared tristate data bus).
- Converts single-cell requests (read, set, clear, toggle) from game logic into row read-modify-write sequences on that bus.
- Runs a 64-row initialisation sweep after every reset.
- Owns bus direction, so the memory is never written by accident.

Parameters:
- ROW_BITS, 64, width of one maze row; equals the codebase `MEMORYSIZE; power of two, 2..64.
- COL_W, 6, column index width; equals log2(ROW_BITS).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_op  input  2  0=read, 1=set, 2=clear, 3=toggle.
- req_row  input  6  target row.
- req_col  input  COL_W  target bit within the row.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_bit  output  1  cell value before the operation.
- init_done  output  1  high once the init sweep completes.
- mem_addr  output  6  memory address.
- mem_cmd  output  1  memory command: 1=read, 0=write.
- mem_data  inout  ROW_BITS  memory data bus.

Behaviour:
- Reset values (while rst_n low, immediate/asynchronous):
  - state=INIT, init counter=0.
  - mem_cmd=1, mem_addr=0, mem_data=Z.
  - req_ready=0, rsp_valid=0, rsp_bit=0, init_done=0.
- Bus rule:
  - mem_data is driven only while mem_cmd=0; otherwise Z.
  - The memory writes on every clock edge that sees mem_cmd=0, so mem_cmd is 0 only in INIT and WR cycles. Every other state holds mem_cmd=1.
- FSM states: INIT, IDLE, RD, WR, RSP.
- INIT:
  - mem_cmd=0, mem_addr=counter, drive init pattern.
  - Counter increments each cycle, 0..63.
  - After the edge that writes row 63: go to IDLE and set init_done=1 (stays 1 until reset).
  - Total: 64 cycles.
- IDLE:
  - req_ready=1.
  - Handshake on any edge with req_valid && req_ready.
  - On handshake, latch op/row/col and go to RD.
  - req_* are ignored in all other states.
- RD:
  - mem_addr=row, mem_cmd=1.
  - At the cycle-end edge, capture mem_data into row_q; the memory read path is combinational.
  - op=read: go to RSP. Otherwise: go to WR.
- WR:
  - mem_addr=row, mem_cmd=0.
  - Drive row_q with bit col forced to 1 (set), 0 (clear) or inverted (toggle); all other bits unchanged.
  - Exactly one write cycle, then RSP.
- RSP:
  - rsp_valid=1 for one cycle; rsp_bit=row_q[col].
  - Then IDLE; req_ready returns to 1 the following cycle.
- Latency, counted from the accepting edge E0:
  - read: rsp_valid high in cycle 2.
  - set/clear/toggle: rsp_valid high in cycle 3.
  - Throughput: one request per 3 (read) or 4 (write) cycles.
- rsp_bit holds its value until the next RSP.
- Column rule: only the low COL_W bits of req_col are used; there is no out-of-range case.
- Back-to-back requests to the same row see the previous write, because the write lands before IDLE.
- Reset mid-operation:
  - Abort immediately; mem_cmd goes to 1 asynchronously.
  - A WR cycle interrupted by reset has undefined row content.
  - The INIT sweep then rewrites all rows.

Optional Feature:
- Macro: MAZE_BORDER_EN.
- Defined: INIT writes a walled border.
  - Rows 0 and 63: all ones.
  - Rows 1..62: bits 0 and ROW_BITS-1 set, all others 0.
- Undefined: INIT writes all zeros to every row.
- FSM timing is identical either way.

Test Plan:
- Reset release → mem_cmd=0 for exactly 64 cycles with mem_addr 0..63, req_ready low throughout; init_done=1 on the next cycle; every row reads 0 (or the border pattern with MAZE_BORDER_EN).
- set row 5 col 10, then read row 5 col 10 → first rsp_bit=0, second rsp_bit=1; row 5 = 0x400 (no border).
- toggle row 63 col 63 twice → rsp_bit 0 then 1; row ends 0. With MAZE_BORDER_EN → rsp_bit 1 then 0; row ends all ones.
- read row 7 → mem_cmd stays 1 for the whole transaction; rsp_valid in cycle 2 after acceptance; rows unchanged.
- req_valid held high continuously with alternating set/clear on row 0 col 3 → accepts spaced 4 cycles apart, one rsp pulse each, no lost or duplicated writes.
- rst_n pulsed low during a WR cycle → mem_cmd=1 and mem_data=Z within the same cycle; full INIT sweep re-runs; rsp_valid not asserted for the aborted request.
